// File: rtl/s1488_state_stage.sv
// Sequential wrapper around the combinational s1488 next-state slices: holds v6..v12,
// registers v0..v5/CLR per step and hands each result off on a valid/ready port.
// Optional result signature MISR enabled by defining S1488_STATE_SIG_EN.
module s1488_state_stage #(
    parameter int unsigned STATE_W = 7,
    parameter int unsigned PI_W    = 6,
    parameter int unsigned CNT_W   = 16,
    parameter logic [STATE_W-1:0] RESET_STATE = '0
) (
    input  logic               CK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PI_W-1:0]    pi,
    input  logic               clr_in,
    output logic [PI_W-1:0]    pi_q,
    output logic               clr_q,
    output logic [STATE_W-1:0] state_q,
    input  logic [STATE_W-1:0] ns,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic [CNT_W-1:0]   step_cnt,
    output logic [15:0]        sig
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } fsm_t;

    fsm_t fsm;
    logic handoff;

    assign handoff  = (fsm == RESP) && out_ready;
    // A new vector may enter in IDLE, or in RESP in the same cycle the result leaves.
    assign in_ready = (fsm == IDLE) || handoff;

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            fsm       <= IDLE;
            state_q   <= RESET_STATE;
            pi_q      <= '0;
            clr_q     <= 1'b0;
            out_state <= '0;
            out_valid <= 1'b0;
            step_cnt  <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        pi_q  <= pi;
                        clr_q <= clr_in;
                        fsm   <= EVAL;
                    end
                end
                EVAL: begin
                    // Slices have seen pi_q/clr_q/state_q for a full cycle; close the loop.
                    state_q   <= ns;
                    out_state <= ns;
                    out_valid <= 1'b1;
                    fsm       <= RESP;
                end
                RESP: begin
                    if (out_ready) begin
                        step_cnt  <= step_cnt + CNT_W'(1);
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            pi_q  <= pi;
                            clr_q <= clr_in;
                            fsm   <= EVAL;
                        end else begin
                            fsm <= IDLE;
                        end
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

`ifdef S1488_STATE_SIG_EN
    // CRC-16-CCITT style MISR folding in each handed-off result.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            sig <= 16'hFFFF;
        end else if (handoff) begin
            sig <= {sig[14:0], sig[15]}
                 ^ (sig[15] ? 16'h1020 : 16'h0000)
                 ^ 16'(out_state);
        end
    end
`else
    assign sig = 16'h0000;
`endif

endmodule

// File: doc/s1488_state_stage.md
Name: s1488_state_stage

Overview:
- Sequential wrapper that closes the loop around the combinational s1488 next-state slices (n65 and siblings).
- Holds the 7 state bits v6..v12 and registers the primary inputs v0..v5 plus CLR for each test step.
- Captures the slices' next-state vector after one evaluation cycle.
- Presents each step's result on a valid/ready handshake so a checker can compare against the original sequential s1488.

Parameters:
- STATE_W, 7, number of state bits (v6..v12, bit 0 = v6).
- PI_W, 6, number of primary inputs (v0..v5, bit 0 = v0).
- CNT_W, 16, width of the completed-step counter.
- RESET_STATE, 7'h00, state register value after reset.

Ports:
- CK  input  1  clock, all flops rising-edge.
- RST  input  1  asynchronous active-high reset.
- in_valid  input  1  step vector offered.
- in_ready  output  1  stage can accept a step vector.
- pi  input  PI_W  primary inputs v0..v5 for the step.
- clr_in  input  1  CLR value for the step.
- pi_q  output  PI_W  registered primary inputs, drives the slices.
- clr_q  output  1  registered CLR, drives the slices.
- state_q  output  STATE_W  current state v6..v12, drives the slices.
- ns  input  STATE_W  next-state vector from the slices (bit 0 = n65's target bit as wired at top level).
- out_valid  output  1  step result available.
- out_ready  input  1  consumer accepts result.
- out_state  output  STATE_W  captured next state of the last step.
- step_cnt  output  CNT_W  number of completed (handed-off) steps.
- sig  output  16  result signature (see Optional Feature).

Behaviour:
- Reset (asynchronous, any state), all outputs cleared:
  - state_q=RESET_STATE; pi_q=0; clr_q=0.
  - out_state=0; out_valid=0; step_cnt=0; sig=0xFFFF (0 without macro).
  - FSM=IDLE.
- FSM states and transitions:
  - IDLE:
    - in_ready=1.
    - Accept when in_valid=1: pi_q<=pi, clr_q<=clr_in, go EVAL.
  - EVAL:
    - Lasts exactly one cycle; in_ready=0; in_valid ignored.
    - Slices see pi_q, clr_q and state_q for the whole cycle.
    - At the closing edge: state_q<=ns, out_state<=ns, out_valid<=1, go RESP.
  - RESP:
    - out_valid=1; out_state stable.
    - in_ready=out_ready (combinational).
    - If out_ready=1: result handed off; step_cnt increments.
      - If in_valid=1 in the same cycle: new vector accepted, go EVAL (back-to-back).
      - Otherwise: out_valid<=0, go IDLE.
    - If out_ready=0: hold everything; no new vector accepted.
- Latency:
  - Accept edge to out_valid high: 2 edges.
  - Sustained throughput: 1 step per 2 cycles.
- ns is sampled only on the EVAL closing edge; it is don't-care elsewhere.
- CLR is not interpreted by this stage; clearing is done by the slices (clr_q=0 forces the n65 bit to 0).
- step_cnt wraps from 2^CNT_W-1 to 0, with no saturation and no flag.
- RST asserted mid-EVAL or mid-RESP discards the step: no increment, state returns to RESET_STATE.
- pi_q and clr_q hold their values until the next accept.

Optional Feature:
- Macro: S1488_STATE_SIG_EN.
- Defined:
  - sig is a 16-bit MISR, seed 0xFFFF, polynomial x^16+x^12+x^5+1 (0x1021).
  - Updated once per handoff (RESP with out_ready=1).
  - Update rule: sig <= {sig[14:0],fb} ^ (fb ? 0x1020 : 0) ^ {9'b0,out_state}, where fb=sig[15].
  - Same update applies to taps and data on every handoff.
- Not defined: sig is constant 0 (reset value 0); no MISR logic is synthesized.

Test Plan:
- Reset value: RST pulse with RESET_STATE=0 -> state_q=0, out_valid=0, in_ready=1, step_cnt=0.
- Single step: pi=6'h15, clr_in=1, ns driven 7'h5A during EVAL, out_ready=1 -> out_valid rises 2 edges after accept, out_state=7'h5A, state_q=7'h5A, step_cnt=1.
- Backpressure: out_ready=0 for 5 cycles in RESP with ns changing -> out_state, state_q and pi_q unchanged; in_ready=0; step_cnt unchanged until out_ready=1.
- Back-to-back steps: in_valid=1 with out_ready=1 held -> new accept every 2 cycles; 10 steps give step_cnt=10, and the final state_q equals the last ns.
- Counter wrap and mid-step reset: CNT_W=4, 16 steps -> step_cnt=0. RST asserted during EVAL -> state_q=RESET_STATE, no increment.
- Signature (S1488_STATE_SIG_EN): from reset, hand off out_state=7'h01 then 7'h7F -> sig matches the reference MISR model. Without the macro, sig=0 throughout.
